// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time-of-day counter / front panel and alarm_ctrl.
// The master side drives time and button inputs; the slave side is the controller.
interface alarm_ctrl_if;
    logic       sec_tick;
    logic [6:0] tmin;
    logic [6:0] thrs;
    logic       alarm_set;
    logic       min_adv;
    logic       hrs_adv;
    logic       alarm_on;
    logic       snooze;
    logic       dismiss;
    logic [6:0] amin;
    logic [6:0] ahrs;
    logic       buzz;
    logic       snoozing;

    modport master (
        output sec_tick, tmin, thrs, alarm_set, min_adv, hrs_adv,
               alarm_on, snooze, dismiss,
        input  amin, ahrs, buzz, snoozing
    );

    modport slave (
        input  sec_tick, tmin, thrs, alarm_set, min_adv, hrs_adv,
               alarm_on, snooze, dismiss,
        output amin, ahrs, buzz, snoozing
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: set-time registers plus IDLE/ARMED/RINGING/SNOOZE state machine.
// Optional macro ALARM_BEEP_EN makes the buzzer pulse 1 s on / 1 s off while ringing.
module alarm_ctrl #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3,
    parameter int HRS_MOD    = 24
) (
    input  logic        Clk,
    input  logic        Reset,
    alarm_ctrl_if.slave bus
);
    localparam logic [6:0] RING_LAST = 7'(RING_SECS - 1);
    localparam logic [6:0] HRS_LAST  = 7'(HRS_MOD - 1);
    localparam logic [7:0] SNZ_ADD   = 8'(SNOOZE_MIN);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    state_t     state_q, state_d;
    logic [6:0] amin_q, amin_d;
    logic [6:0] ahrs_q, ahrs_d;
    logic [6:0] ring_cnt_q, ring_cnt_d;
    logic [2:0] snz_cnt_q, snz_cnt_d;
    logic [6:0] tgt_min_q, tgt_min_d;
    logic [6:0] tgt_hrs_q, tgt_hrs_d;
    logic       match_q, match_d;
    logic       buzz_q, buzz_d;
    logic       snoozing_q, snoozing_d;

    logic       trigger;
    logic       at_target;
    logic [7:0] snz_sum;
    logic [6:0] snz_min;
    logic [6:0] snz_hrs;

    always_comb begin
        amin_d = amin_q;
        ahrs_d = ahrs_q;
        if (bus.alarm_set && bus.min_adv)
            amin_d = (amin_q == 7'd59) ? 7'd0 : amin_q + 7'd1;
        if (bus.alarm_set && bus.hrs_adv)
            ahrs_d = (ahrs_q == HRS_LAST) ? 7'd0 : ahrs_q + 7'd1;
    end

    // Rising edge of the minute match, so arming inside the minute never rings.
    assign match_d   = (bus.tmin == amin_q) && (bus.thrs == ahrs_q);
    assign trigger   = match_d && !match_q;
    assign at_target = (bus.tmin == tgt_min_q) && (bus.thrs == tgt_hrs_q);

    always_comb begin
        snz_sum = {1'b0, bus.tmin} + SNZ_ADD;
        snz_min = snz_sum[6:0];
        snz_hrs = bus.thrs;
        if (snz_sum >= 8'd60) begin
            snz_min = 7'(snz_sum - 8'd60);
            snz_hrs = (bus.thrs == HRS_LAST) ? 7'd0 : bus.thrs + 7'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        tgt_min_d  = tgt_min_q;
        tgt_hrs_d  = tgt_hrs_q;
        if (!bus.alarm_on) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (!bus.alarm_set && trigger) begin
                        state_d    = RINGING;
                        ring_cnt_d = 7'd0;
                        snz_cnt_d  = 3'd0;
                    end
                end
                RINGING: begin
                    if (bus.alarm_set || bus.dismiss) begin
                        state_d = ARMED;
                    end else if (bus.snooze && (snz_cnt_q < SNZ_MAX)) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = snz_cnt_q + 3'd1;
                        tgt_min_d = snz_min;
                        tgt_hrs_d = snz_hrs;
                    end else if (bus.sec_tick) begin
                        if (ring_cnt_q == RING_LAST)
                            state_d = ARMED;
                        else
                            ring_cnt_d = ring_cnt_q + 7'd1;
                    end
                end
                SNOOZE: begin
                    if (bus.alarm_set || bus.dismiss) begin
                        state_d = ARMED;
                    end else if (at_target) begin
                        state_d    = RINGING;
                        ring_cnt_d = 7'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef ALARM_BEEP_EN
    logic beep_q, beep_d;

    always_comb begin
        beep_d = beep_q;
        if (state_d == RINGING && state_q != RINGING)
            beep_d = 1'b1;
        else if (state_q == RINGING && bus.sec_tick)
            beep_d = ~beep_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) beep_q <= 1'b1;
        else       beep_q <= beep_d;
    end

    assign buzz_d = (state_d == RINGING) && beep_d;
`else
    assign buzz_d = (state_d == RINGING);
`endif

    assign snoozing_d = (state_d == SNOOZE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            amin_q     <= 7'd0;
            ahrs_q     <= 7'd0;
            ring_cnt_q <= 7'd0;
            snz_cnt_q  <= 3'd0;
            tgt_min_q  <= 7'd0;
            tgt_hrs_q  <= 7'd0;
            match_q    <= 1'b0;
            buzz_q     <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            amin_q     <= amin_d;
            ahrs_q     <= ahrs_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            tgt_min_q  <= tgt_min_d;
            tgt_hrs_q  <= tgt_hrs_d;
            match_q    <= match_d;
            buzz_q     <= buzz_d;
            snoozing_q <= snoozing_d;
        end
    end

    assign bus.amin     = amin_q;
    assign bus.ahrs     = ahrs_q;
    assign bus.buzz     = buzz_q;
    assign bus.snoozing = snoozing_q;
endmodule
